hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the combinational load-use checker. Sits beside the ID stage.
//  Keeps one pending-write countdown per architectural register and stalls ID until every
//  source it needs can be read or forwarded. Handles ALU, load and branch-in-ID consumers,
//  with forwarding switchable at run time. Also exports stall-cause and stall-count statistics.
// PARAMETERS
//  NUM_REGS    32  architectural registers; register 0 is hardwired and never tracked
//  REG_AW      5   register index width, equal to clog2(NUM_REGS)
//  LOAD_LAT    1   extra cycles a load result lags an ALU result when forwarding is on
//  NOFWD_LAT   2   stall cycles a dependent EX consumer needs when forwarding is off
//  BR_EXTRA    1   extra cycle a branch compared in ID needs over an EX consumer
//  PERF_W      16  stall-counter width
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         synchronous reset, active-high
//  id_valid     in   1         an instruction is present in ID
//  id_src1      in   REG_AW    rs
//  id_src2      in   REG_AW    rt
//  id_src2_used in   1         rt is read (R-type, SW, BEQ/BNE)
//  id_is_branch in   1         ID instruction compares its operands in ID
//  id_we        in   1         ID instruction writes a register
//  id_dest      in   REG_AW    destination register
//  id_is_load   in   1         ID instruction is a load (Mem_to_Reg)
//  forward_en   in   1         forwarding paths enabled
//  flush        in   1         kill the ID instruction this cycle (taken branch/jump)
//  stall        out  1         hold PC and IF/ID; insert a bubble into ID/EX
//  stall_cause  out  2         0 none, 1 load-use, 2 branch-operand, 3 no-forward
//  busy         out  NUM_REGS  bit r set while cnt[r] != 0
//  stall_cycles out  PERF_W    saturating count of stalled cycles
// BEHAVIOUR
//  - State: cnt[r] is CW bits wide, with CW = clog2(NOFWD_LAT+LOAD_LAT+BR_EXTRA+1).
//    ld[r] is 1 bit. cnt[r] counts cycles until r is usable by a branch in ID.
//  - Reset: all cnt and ld are 0, stall_cycles is 0. Outputs stall=0, cause=0, busy=0.
//  - Required wait for source s, with s != 0:
//    - branch consumer: need = cnt[s] != 0.
//    - EX consumer: need = cnt[s] > BR_EXTRA.
//    - src2 is checked only when id_src2_used=1.
//  - stall = id_valid & ~flush & (need(src1) | need(src2)). It is combinational and
//    computed from current-cycle counters (zero latency).
//  - stall_cause is computed whenever stall=1, using this priority:
//    - 3 when forward_en=0;
//    - else 1 when a needed source has ld=1 and cnt > BR_EXTRA;
//    - else 2.
//    stall_cause is 0 when stall=0.
//  - Accept = id_valid & ~flush & ~stall & id_we & (id_dest != 0). On accept:
//    - cnt[id_dest] <= base + BR_EXTRA, where base is NOFWD_LAT if forward_en=0,
//      else LOAD_LAT if id_is_load=1, else 0.
//    - ld[id_dest] <= id_is_load & forward_en.
//  - Every other register decrements by 1 per cycle, saturating at 0. Decrement continues
//    during stall. On accept, the write to id_dest overrides its decrement that cycle.
//  - A stalled instruction never modifies the scoreboard. It is re-evaluated each cycle
//    until it is accepted.
//  - flush has priority over stall. It forces stall=0 and no accept. Older pending
//    counters are kept: those producers are already past ID and will still write.
//  - forward_en change: it affects only newly accepted producers. Existing counters
//    finish as loaded.
//  - stall_cycles increments on every stall=1 cycle and holds at all-ones.
//  - A destination equal to a source of the same instruction does not cause a
//    self-stall, because the check uses pre-update counters.
//  - rst mid-stall clears everything on the next edge. stall is 0 in the following cycle.
// STRUCTURE
//  - Shared package hazard_pkg holds the CW computation and the STALL_NONE/LOADUSE/BRANCH/
//    NOFWD cause codes. The pipeline stall mux and the perf block import it.
//  - One natural sub-module: sb_counter (CW-bit saturating down-counter, load-overrides-
//    decrement, plus ld bit), instantiated NUM_REGS-1 times in a generate loop.
//  - Source lookup mux and cause priority encoder stay in the top.
// TESTING
//  - Default parameters, forward_en=1, as in all tests unless stated. Cycle 0: LW r8;
//    cycle 1: ADD r9,r8,r1 -> stall=1 cause=1 for 1 cycle, accepted in cycle 2,
//    stall_cycles=1.
//  - ADD r8 in cycle 0; cycle 1: BEQ r8,r2 -> 1 stall cycle, cause=2.
//    Same sequence with ADD as the consumer -> no stall.
//  - forward_en=0. ADD r8 then SUB r3,r8,r4 -> stall 2 cycles, cause=3.
//    SW r8 with id_src2_used=1 -> stall 2 cycles. ORI r3,r8 with id_src2_used=0 and
//    src2=r8 only -> no stall.
//  - LW r8 then BEQ r8 -> stall 2 cycles. flush asserted on the 1st stall cycle ->
//    stall=0 that cycle, busy[8] keeps counting down, stall_cycles unchanged.
//  - LW r0 followed by a consumer of r0 -> never stalls, busy[0]=0 throughout.
//    Producer with dest=rs of itself -> no self-stall.
//  - rst asserted while stall=1 with cnt[8]=2 -> next cycle busy=0, stall=0,
//    stall_cycles=0. Also force 2^16+5 stall cycles -> stall_cycles saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: stall-cause codes and the
// countdown width helper used to size the per-register counters.
package hazard_pkg;

  typedef enum logic [1:0] {
    STALL_NONE    = 2'd0,
    STALL_LOADUSE = 2'd1,
    STALL_BRANCH  = 2'd2,
    STALL_NOFWD   = 2'd3
  } stall_cause_e;

  // Counter width wide enough for the longest possible countdown value.
  function automatic int cnt_width(input int nofwd_lat, input int load_lat, input int br_extra);
    int w;
    w = $clog2(nofwd_lat + load_lat + br_extra + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// One scoreboard entry: saturating down-counter of cycles until the register
// is readable by a branch in ID, plus a flag marking a load producer.
module sb_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [CW-1:0] load_val,
  input  logic          load_ld,
  output logic [CW-1:0] cnt_o,
  output logic          ld_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_q, ld_d;

  // A new producer overrides the countdown; otherwise count down and stop at zero.
  always_comb begin
    cnt_d = (cnt_q != '0) ? (cnt_q - CW'(1)) : cnt_q;
    ld_d  = ld_q;
    if (load_en) begin
      cnt_d = load_val;
      ld_d  = load_ld;
    end
  end

  // Entry state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ld_o  = ld_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: one pending-write countdown per architectural
// register, zero-latency stall decision, stall cause and a stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int NOFWD_LAT = 2,
  parameter int BR_EXTRA  = 1,
  parameter int PERF_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_src1,
  input  logic [REG_AW-1:0]   id_src2,
  input  logic                id_src2_used,
  input  logic                id_is_branch,
  input  logic                id_we,
  input  logic [REG_AW-1:0]   id_dest,
  input  logic                id_is_load,
  input  logic                forward_en,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          stall_cause,
  output logic [NUM_REGS-1:0] busy,
  output logic [PERF_W-1:0]   stall_cycles
);

  localparam int CW = cnt_width(NOFWD_LAT, LOAD_LAT, BR_EXTRA);

  // A count above this threshold still blocks an EX consumer; a branch in ID
  // needs BR_EXTRA more cycles, so it waits for the count to reach zero.
  localparam logic [CW-1:0] BR_THR    = CW'(BR_EXTRA);
  localparam logic [CW-1:0] VAL_ALU   = CW'(BR_EXTRA);
  localparam logic [CW-1:0] VAL_LOAD  = CW'(LOAD_LAT + BR_EXTRA);
  localparam logic [CW-1:0] VAL_NOFWD = CW'(NOFWD_LAT + BR_EXTRA);

  logic [CW-1:0]       cnt [NUM_REGS];
  logic [NUM_REGS-1:0] ld_bits;

  logic [CW-1:0] cnt_s1, cnt_s2;
  logic          ld_s1, ld_s2;
  logic          need1, need2;
  logic          lu1, lu2;
  logic          accept;
  logic [CW-1:0] load_val;
  logic          load_ld;
  stall_cause_e  cause;

  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

  // Register 0 is hardwired: never pending, never a load.
  assign cnt[0]     = '0;
  assign ld_bits[0] = 1'b0;
  assign busy[0]    = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic load_en_r;
    assign load_en_r = accept & (id_dest == REG_AW'(r));

    sb_counter #(.CW(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load_en  (load_en_r),
      .load_val (load_val),
      .load_ld  (load_ld),
      .cnt_o    (cnt[r]),
      .ld_o     (ld_bits[r])
    );

    assign busy[r] = (cnt[r] != '0);
  end

  // Source lookup; an unused rt reads as "nothing pending".
  always_comb begin
    cnt_s1 = cnt[id_src1];
    ld_s1  = ld_bits[id_src1];
    cnt_s2 = '0;
    ld_s2  = 1'b0;
    if (id_src2_used) begin
      cnt_s2 = cnt[id_src2];
      ld_s2  = ld_bits[id_src2];
    end
  end

  // Per-source wait decision and whether the wait is due to a load result.
  always_comb begin
    need1 = id_is_branch ? (cnt_s1 != '0) : (cnt_s1 > BR_THR);
    need2 = id_is_branch ? (cnt_s2 != '0) : (cnt_s2 > BR_THR);
    lu1   = need1 & ld_s1 & (cnt_s1 > BR_THR);
    lu2   = need2 & ld_s2 & (cnt_s2 > BR_THR);
    stall = id_valid & ~flush & (need1 | need2);
  end

  // Cause priority: forwarding off, then load-use, otherwise branch operand.
  always_comb begin
    cause = STALL_NONE;
    if (stall) begin
      if (!forward_en)     cause = STALL_NOFWD;
      else if (lu1 | lu2)  cause = STALL_LOADUSE;
      else                 cause = STALL_BRANCH;
    end
  end

  assign stall_cause = cause;

  // Accept decision and the countdown value loaded for the new producer.
  always_comb begin
    accept   = id_valid & ~flush & ~stall & id_we & (id_dest != '0);
    load_ld  = id_is_load & forward_en;
    load_val = VAL_ALU;
    if (!forward_en)     load_val = VAL_NOFWD;
    else if (id_is_load) load_val = VAL_LOAD;
  end

  // Stall-cycle counter, saturating at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + PERF_W'(1);
  end

  // Perf counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int BR = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_src1 = '0;
  logic [4:0]  id_src2 = '0;
  logic        id_src2_used = 1'b0;
  logic        id_is_branch = 1'b0;
  logic        id_we = 1'b0;
  logic [4:0]  id_dest = '0;
  logic        id_is_load = 1'b0;
  logic        forward_en = 1'b1;
  logic        flush = 1'b0;

  logic        stall, stall_s;
  logic [1:0]  stall_cause, stall_cause_s;
  logic [31:0] busy, busy_s;
  logic [15:0] stall_cycles;
  logic [5:0]  stall_cycles_s;

  int total = 0;
  int bad = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src2_used(id_src2_used), .id_is_branch(id_is_branch), .id_we(id_we),
    .id_dest(id_dest), .id_is_load(id_is_load), .forward_en(forward_en), .flush(flush),
    .stall(stall), .stall_cause(stall_cause), .busy(busy), .stall_cycles(stall_cycles)
  );

  // Narrow perf counter instance so saturation is reachable in a short run.
  hazard_scoreboard #(.PERF_W(6)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src2_used(id_src2_used), .id_is_branch(id_is_branch), .id_we(id_we),
    .id_dest(id_dest), .id_is_load(id_is_load), .forward_en(forward_en), .flush(flush),
    .stall(stall_s), .stall_cause(stall_cause_s), .busy(busy_s), .stall_cycles(stall_cycles_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each register remembers the cycle at which it becomes
  // usable by a branch in ID; pending cycles are the distance to that cycle.
  int  ready_at [32];
  bit  from_load [32];
  int  cyc = 0;
  bit  mvalid = 0;
  int  m_sc = 0;
  int  m_sc_s = 0;

  function automatic int pend(input int r);
    int p;
    if (r == 0) return 0;
    p = ready_at[r] - cyc;
    return (p > 0) ? p : 0;
  endfunction

  always @(negedge clk) begin
    int p1, p2, k;
    bit n1, n2, l1, l2, e_stall, acc;
    int e_cause;
    logic [31:0] e_busy;
    if (mvalid) begin
      p1 = pend(int'(id_src1));
      p2 = id_src2_used ? pend(int'(id_src2)) : 0;
      n1 = id_is_branch ? (p1 > 0) : (p1 > BR);
      n2 = id_is_branch ? (p2 > 0) : (p2 > BR);
      l1 = n1 && from_load[id_src1] && (p1 > BR);
      l2 = n2 && id_src2_used && from_load[id_src2] && (p2 > BR);
      e_stall = id_valid && !flush && (n1 || n2);
      e_cause = !e_stall ? 0 : (!forward_en ? 3 : ((l1 || l2) ? 1 : 2));
      for (int r = 0; r < 32; r++) e_busy[r] = (pend(r) > 0);
      chk("m_stall", 32'(stall), 32'(e_stall));
      chk("m_cause", 32'(stall_cause), 32'(e_cause));
      chk("m_busy", busy, e_busy);
      chk("m_sc", 32'(stall_cycles), 32'(m_sc));
      chk("m_sc_small", 32'(stall_cycles_s), 32'(m_sc_s));
      if (!rst) begin
        if (e_stall) begin
          if (m_sc < 65535) m_sc++;
          if (m_sc_s < 63) m_sc_s++;
        end
        acc = id_valid && !flush && !e_stall && id_we && (id_dest != 0);
        if (acc) begin
          k = (!forward_en ? 2 : (id_is_load ? 1 : 0)) + BR;
          ready_at[id_dest]  = cyc + 1 + k;
          from_load[id_dest] = id_is_load && forward_en;
        end
      end
    end
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        ready_at[r] = 0;
        from_load[r] = 0;
      end
      m_sc = 0;
      m_sc_s = 0;
      mvalid = 1;
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit v, input int s1, input int s2, input bit used,
                     input bit br, input bit we, input int dest, input bit ld);
    id_valid = v; id_src1 = 5'(s1); id_src2 = 5'(s2); id_src2_used = used;
    id_is_branch = br; id_we = we; id_dest = 5'(dest); id_is_load = ld;
  endtask

  task automatic drain(input int n);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    flush = 0;
    repeat (n) tick;
  endtask

  initial begin
    repeat (2) tick;
    rst = 0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_cause", 32'(stall_cause), 0);
    chk("rst_busy", busy, 0);
    chk("rst_sc", 32'(stall_cycles), 0);
    tick;

    // LW r8 then ADD r9,r8,r1: one load-use stall
    put(1, 1, 0, 0, 0, 1, 8, 1);
    @(negedge clk); chk("lu_c0_stall", 32'(stall), 0);
    tick;
    put(1, 8, 1, 1, 0, 1, 9, 0);
    @(negedge clk);
    chk("lu_c1_stall", 32'(stall), 1);
    chk("lu_c1_cause", 32'(stall_cause), 1);
    chk("lu_c1_busy8", 32'(busy[8]), 1);
    tick;
    @(negedge clk);
    chk("lu_c2_stall", 32'(stall), 0);
    chk("lu_c2_sc", 32'(stall_cycles), 1);
    tick;
    drain(4);

    // ADD r8 then BEQ r8,r2: one branch stall; ADD consumer: none
    put(1, 1, 2, 1, 0, 1, 8, 0); tick;
    put(1, 8, 2, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("br_c1_stall", 32'(stall), 1);
    chk("br_c1_cause", 32'(stall_cause), 2);
    tick;
    @(negedge clk); chk("br_c2_stall", 32'(stall), 0);
    tick;
    drain(3);
    put(1, 1, 2, 1, 0, 1, 8, 0); tick;
    put(1, 8, 2, 1, 0, 1, 10, 0);
    @(negedge clk); chk("alu_fwd_stall", 32'(stall), 0);
    tick;
    drain(4);

    // Forwarding off
    forward_en = 0;
    put(1, 1, 2, 1, 0, 1, 8, 0); tick;
    put(1, 8, 4, 1, 0, 1, 3, 0);
    @(negedge clk); chk("nf_c1_stall", 32'(stall), 1); chk("nf_c1_cause", 32'(stall_cause), 3);
    tick;
    @(negedge clk); chk("nf_c2_stall", 32'(stall), 1); chk("nf_c2_cause", 32'(stall_cause), 3);
    tick;
    @(negedge clk); chk("nf_c3_stall", 32'(stall), 0);
    tick;
    drain(4);
    put(1, 1, 2, 1, 0, 1, 8, 0); tick;
    put(1, 29, 8, 1, 0, 0, 0, 0);
    @(negedge clk); chk("sw_c1_stall", 32'(stall), 1);
    tick;
    @(negedge clk); chk("sw_c2_stall", 32'(stall), 1);
    tick;
    @(negedge clk); chk("sw_c3_stall", 32'(stall), 0);
    tick;
    drain(4);
    put(1, 1, 2, 1, 0, 1, 8, 0); tick;
    put(1, 4, 8, 0, 0, 1, 3, 0);
    @(negedge clk); chk("ori_stall", 32'(stall), 0);
    tick;
    drain(4);
    forward_en = 1;

    // LW r8 then BEQ r8: two stalls
    put(1, 1, 0, 0, 0, 1, 8, 1); tick;
    put(1, 8, 2, 1, 1, 0, 0, 0);
    @(negedge clk); chk("lb_c1_stall", 32'(stall), 1); chk("lb_c1_cause", 32'(stall_cause), 1);
    tick;
    @(negedge clk); chk("lb_c2_stall", 32'(stall), 1); chk("lb_c2_cause", 32'(stall_cause), 2);
    tick;
    @(negedge clk); chk("lb_c3_stall", 32'(stall), 0);
    tick;
    drain(4);

    // Same with flush on the first stall cycle
    put(1, 1, 0, 0, 0, 1, 8, 1); tick;
    put(1, 8, 2, 1, 1, 0, 0, 0);
    flush = 1;
    @(negedge clk); chk("fl_c1_stall", 32'(stall), 0); chk("fl_c1_busy8", 32'(busy[8]), 1);
    tick;
    flush = 0;
    @(negedge clk); chk("fl_c2_stall", 32'(stall), 1); chk("fl_c2_busy8", 32'(busy[8]), 1);
    tick;
    @(negedge clk); chk("fl_c3_stall", 32'(stall), 0); chk("fl_c3_busy8", 32'(busy[8]), 0);
    tick;
    drain(4);

    // r0 never tracked; no self-stall
    put(1, 1, 0, 0, 0, 1, 0, 1);
    @(negedge clk); chk("r0_c0_busy", busy, 0);
    tick;
    put(1, 0, 0, 1, 0, 1, 5, 0);
    @(negedge clk); chk("r0_c1_stall", 32'(stall), 0); chk("r0_c1_busy0", 32'(busy[0]), 0);
    tick;
    drain(4);
    put(1, 7, 1, 1, 0, 1, 7, 0);
    @(negedge clk); chk("self_stall", 32'(stall), 0);
    tick;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("self_busy7", 32'(busy[7]), 1);
    tick;
    drain(4);

    // Reset in the middle of a stall
    put(1, 1, 0, 0, 0, 1, 8, 1); tick;
    put(1, 8, 1, 1, 0, 1, 9, 0);
    rst = 1;
    @(negedge clk); chk("rs_c1_stall", 32'(stall), 1); chk("rs_c1_busy8", 32'(busy[8]), 1);
    tick;
    rst = 0;
    @(negedge clk);
    chk("rs_c2_busy", busy, 0);
    chk("rs_c2_stall", 32'(stall), 0);
    chk("rs_c2_sc", 32'(stall_cycles), 0);
    tick;
    drain(4);

    // Saturation: 24 rounds of 3 stall cycles each
    forward_en = 0;
    for (int i = 0; i < 24; i++) begin
      put(1, 1, 2, 1, 0, 1, 8, 0); tick;
      put(1, 8, 8, 1, 1, 0, 0, 0); repeat (4) tick;
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat_small", 32'(stall_cycles_s), 32'h3F);
    chk("sat_main", 32'(stall_cycles), 72);
    tick;
    forward_en = 1;
    drain(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
